// File: rtl/mem_access_ctrl.sv
// CPU-side initiator for the SLC-3 memory/IO bridge: latches one request into
// MAR/MDR, holds OE or WE for a fixed wait count, then pulses a response.
module mem_access_ctrl #(
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic [15:0] ADDR,
  output logic        OE,
  output logic        WE,
  output logic [15:0] Data_from_CPU,
  input  logic [15:0] Data_to_CPU
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [3:0] RD_LAST = 4'(READ_WAIT - 1);
  localparam logic [3:0] WR_LAST = 4'(WRITE_WAIT - 1);

  state_t      state_reg, state_next;
  logic [15:0] mar_reg, mar_next;
  logic [15:0] mdr_reg, mdr_next;
  logic [3:0]  cnt_reg, cnt_next;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= IDLE;
      mar_reg   <= 16'h0000;
      mdr_reg   <= 16'h0000;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      mar_reg   <= mar_next;
      mdr_reg   <= mdr_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    mar_next   = mar_reg;
    mdr_next   = mdr_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      IDLE: begin
        if (req_valid) begin
          mar_next = req_addr;
          cnt_next = 4'd0;
          if (req_we) begin
            mdr_next   = req_wdata;
            state_next = WR;
          end else begin
            state_next = RD;
          end
        end
      end
      RD: begin
        cnt_next = cnt_reg + 4'd1;
        if (cnt_reg == RD_LAST) begin
          mdr_next   = Data_to_CPU;
          state_next = RESP;
        end
      end
      WR: begin
        cnt_next = cnt_reg + 4'd1;
        if (cnt_reg == WR_LAST) begin
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Strobes come straight from the state register so OE and WE are mutually
  // exclusive and glitch-free; ADDR/data simply mirror MAR/MDR.
  assign req_ready     = (state_reg == IDLE);
  assign OE            = (state_reg == RD);
  assign WE            = (state_reg == WR);
  assign rsp_valid     = (state_reg == RESP);
  assign ADDR          = mar_reg;
  assign Data_from_CPU = mdr_reg;
  assign rsp_rdata     = mdr_reg;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: hand-computed per-cycle expectations for
// reads, writes, busy/ignore, reset abort and switch readback.
module tb_mem_access_ctrl;

  localparam int RW = 2;
  localparam int WW = 2;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        req_valid;
  logic        req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic [15:0] ADDR;
  logic        OE;
  logic        WE;
  logic [15:0] Data_from_CPU;
  logic [15:0] Data_to_CPU;

  int errors = 0;
  int checks = 0;

  mem_access_ctrl #(.READ_WAIT(RW), .WRITE_WAIT(WW)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .req_valid     (req_valid),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .ADDR          (ADDR),
    .OE            (OE),
    .WE            (WE),
    .Data_from_CPU (Data_from_CPU),
    .Data_to_CPU   (Data_to_CPU)
  );

  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
    checks++;
    if (obs !== exp_val) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp_val, $time);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  // Issue one request from IDLE and check every cycle until IDLE returns.
  // k counts negedges after the accepting edge: enable high for k=1..W,
  // response at k=W+1, ready again at k=W+2.
  task automatic run_txn(input string name, input logic we, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [15:0] din,
                         input logic [15:0] exp_mdr);
    int w;
    w = we ? WW : RW;
    req_valid   = 1'b1;
    req_we      = we;
    req_addr    = addr;
    req_wdata   = wdata;
    Data_to_CPU = din;
    check_val({name, ".ready_at_issue"}, 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    req_addr  = ~addr;
    req_wdata = ~wdata;
    for (int k = 1; k <= w + 2; k++) begin
      check_val($sformatf("%s.oe[%0d]", name, k), 32'(OE), 32'(!we && k <= w));
      check_val($sformatf("%s.we[%0d]", name, k), 32'(WE), 32'(we && k <= w));
      check_val($sformatf("%s.addr[%0d]", name, k), 32'(ADDR), 32'(addr));
      check_val($sformatf("%s.rsp[%0d]", name, k), 32'(rsp_valid), 32'(k == w + 1));
      check_val($sformatf("%s.ready[%0d]", name, k), 32'(req_ready), 32'(k == w + 2));
      if (we) check_val($sformatf("%s.dfc[%0d]", name, k), 32'(Data_from_CPU), 32'(wdata));
      if (k == w + 1) check_val({name, ".rdata"}, 32'(rsp_rdata), 32'(exp_mdr));
      if (k < w + 2) step();
    end
  endtask

  initial begin
    int pulses;
    Reset       = 1'b1;
    req_valid   = 1'b1;
    req_we      = 1'b1;
    req_addr    = 16'h5555;
    req_wdata   = 16'h7777;
    Data_to_CPU = 16'h0000;

    // Reset held two cycles with a request pending
    step();
    step();
    check_val("rst.oe", 32'(OE), 32'd0);
    check_val("rst.we", 32'(WE), 32'd0);
    check_val("rst.rsp", 32'(rsp_valid), 32'd0);
    check_val("rst.addr", 32'(ADDR), 32'd0);
    check_val("rst.rdata", 32'(rsp_rdata), 32'd0);
    check_val("rst.dfc", 32'(Data_from_CPU), 32'd0);
    Reset     = 1'b0;
    req_valid = 1'b0;
    step();
    check_val("rst.ready", 32'(req_ready), 32'd1);
    check_val("rst.no_txn_addr", 32'(ADDR), 32'd0);
    check_val("rst.no_txn_we", 32'(WE), 32'd0);

    run_txn("rd", 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 16'hBEEF);
    run_txn("wr", 1'b1, 16'hFFFF, 16'h1234, 16'h0000, 16'h1234);
    check_val("wr.idle_addr", 32'(ADDR), 32'hFFFF);

    // Busy/ignore: request stays asserted, address changes mid-read
    req_valid   = 1'b1;
    req_we      = 1'b0;
    req_addr    = 16'h0100;
    Data_to_CPU = 16'h5A5A;
    step();
    req_addr = 16'h0ABC;
    for (int k = 1; k <= RW + 2; k++) begin
      check_val($sformatf("busy.addr[%0d]", k), 32'(ADDR), 32'h0100);
      check_val($sformatf("busy.oe[%0d]", k), 32'(OE), 32'(k <= RW));
      check_val($sformatf("busy.ready[%0d]", k), 32'(req_ready), 32'(k == RW + 2));
      if (k == RW + 1) check_val("busy.rdata", 32'(rsp_rdata), 32'h5A5A);
      step();
    end
    req_valid = 1'b0;
    check_val("busy2.addr", 32'(ADDR), 32'h0ABC);
    check_val("busy2.oe", 32'(OE), 32'd1);
    check_val("busy2.ready", 32'(req_ready), 32'd0);
    step();
    step();
    check_val("busy2.rsp", 32'(rsp_valid), 32'd1);
    step();
    check_val("busy2.ready_back", 32'(req_ready), 32'd1);

    // Reset during the first OE cycle aborts the read
    req_valid   = 1'b1;
    req_we      = 1'b0;
    req_addr    = 16'h0020;
    Data_to_CPU = 16'h1111;
    step();
    req_valid = 1'b0;
    check_val("abort.oe_before", 32'(OE), 32'd1);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check_val("abort.oe", 32'(OE), 32'd0);
    check_val("abort.we", 32'(WE), 32'd0);
    check_val("abort.rdata", 32'(rsp_rdata), 32'd0);
    check_val("abort.addr", 32'(ADDR), 32'd0);
    check_val("abort.ready", 32'(req_ready), 32'd1);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      if (rsp_valid) pulses++;
      step();
    end
    check_val("abort.no_rsp", 32'(pulses), 32'd0);
    check_val("abort.rdata_after", 32'(rsp_rdata), 32'd0);

    run_txn("sw_rd", 1'b0, 16'hFFFF, 16'h0000, 16'h03FF, 16'h03FF);
    run_txn("sw_wr", 1'b1, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF);
    check_val("sw_wr.idle_rdata", 32'(rsp_rdata), 32'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
